// File: rtl/rs232_pkg.sv
// rs232 link shared definitions.
// Line timing defaults and receiver FSM encoding.
package rs232_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to 1 so an idle serial line stays idle.
module rs232_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/rs232_rx.sv
// UART 8N1 receiver: start detect, mid-bit sampling,
// one-cycle valid / framing-error strobes.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rxd_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rxd_sync;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 err_q;

  rs232_sync u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (rxd_in),
    .q_out  (rxd_sync)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_sync) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxd_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shift_q <= {rxd_sync, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is caught
          if (cnt_q == BIT_M1) begin
            cnt_q <= '0;
            if (rxd_sync) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BREAK: begin
          if (rxd_sync) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = err_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// Directed + randomized bench for rs232_rx.
// Expected strobes come from frame-level timing arithmetic.
module tb_rs232_rx;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (DB + 1) * CPB + 1;

  typedef struct {
    int unsigned cyc;
    bit          err;
    logic [7:0]  d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       busy_out;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          both = 0;
  logic [7:0]  last_good = 8'h00;
  ev_t         exp_q[$];
  ev_t         got_q[$];

  rs232_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rxd_in        (rxd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) got_q.push_back('{cyc, 1'b0, data_out});
    if (frame_err_out === 1'b1) got_q.push_back('{cyc, 1'b1, 8'h00});
    if (valid_out === 1'b1 && frame_err_out === 1'b1) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the fall happens now.
  task automatic send(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back('{cyc + LAT, 1'b0, b});
    end else begin
      exp_q.push_back('{cyc + LAT, 1'b1, 8'h00});
    end
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_kind"}, 32'(got_q[i].err), 32'(exp_q[i].err));
      chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int bad;
    int busy_lo;
    logic [7:0] b;

    // Reset and idle
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_err", 32'(frame_err_out), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
    got_q.delete();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid_out !== 1'b0 || frame_err_out !== 1'b0 ||
          busy_out !== 1'b0 || data_out !== 8'h00) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Single frame
    send(8'hA5, 1'b1);
    last_good = 8'hA5;
    idle(20);
    check_events("a5");
    chk("a5_dout", 32'(data_out), 32'(last_good));

    // Back-to-back, no idle gap
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    last_good = 8'hFF;
    idle(20);
    check_events("b2b");

    // Glitch rejection
    rxd = 1'b0;
    idle(3);
    chk("glitch_busy_hi", 32'(busy_out), 32'h1);
    rxd = 1'b1;
    idle(HALF);
    chk("glitch_busy_lo", 32'(busy_out), 32'h0);
    idle(CPB * 12);
    check_events("glitch");

    // Random frames with random gaps
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      send(b, 1'b1);
      last_good = b;
      idle($urandom_range(0, 20));
    end
    idle(20);
    check_events("rand");
    chk("rand_dout", 32'(data_out), 32'(last_good));

    // Framing error followed by a long break
    send(8'h3C, 1'b0);
    bad = 0;
    for (int i = 0; i < 40 * CPB; i++) begin
      @(negedge clk);
      if (data_out !== last_good || busy_out !== 1'b1) bad++;
    end
    chk("break_hold", bad, 0);
    rxd = 1'b1;
    busy_lo = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_out === 1'b0) busy_lo = 1;
    end
    chk("break_exit", busy_lo, 1);
    send(8'h5A, 1'b1);
    last_good = 8'h5A;
    idle(20);
    check_events("ferr");
    chk("ferr_dout", 32'(data_out), 32'(last_good));

    // Reset in the middle of a frame
    b = 8'h77;
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rst = 1'b1;
    rxd = 1'b1;
    idle(1);
    chk("midrst_busy", 32'(busy_out), 32'h0);
    rst = 1'b0;
    last_good = 8'h00;
    idle(CPB * 10);
    chk("midrst_dout", 32'(data_out), 32'(last_good));
    send(8'h81, 1'b1);
    last_good = 8'h81;
    idle(20);
    check_events("midrst");
    chk("midrst_dout2", 32'(data_out), 32'(last_good));

    chk("never_both", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- UART receive front end for the rs232 link. Feeds the byte path that the existing rs232 transmitter echoes out on txd_out.
- Synchronises asynchronous rxd_in and detects the start bit, then samples 8N1 frames at bit centres.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Single clock domain (clk_in). No flow control: the consumer must accept data on the valid strobe.

Parameters:
- CLKS_PER_BIT, 434, clk_in cycles per bit (50 MHz / 115200). Must be >= 4.
- DATA_BITS, 8, data bits per frame. Sent LSB first.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rxd_in  input  1  asynchronous serial line; idles high.
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- valid_out  output  1  one-cycle pulse; data_out is new in this cycle.
- frame_err_out  output  1  one-cycle pulse; stop bit sampled low.
- busy_out  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_in high at a clk_in edge):
  - sync flops = 1, state = IDLE, bit counter and clock counter = 0, shift register = 0.
  - data_out = 0, valid_out = 0, frame_err_out = 0, busy_out = 0.
  - Reset overrides all other activity, including reset mid-frame. A partial frame is discarded with no strobe.
- Synchroniser: 2 flops. rxd_sync lags rxd_in by 2 cycles. All FSM decisions use rxd_sync only.
- HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxd_sync==0 in cycle t0 -> START, clock counter cleared.
- START:
  - Counts to HALF-1, then samples rxd_sync at t0+HALF.
  - Sample 0 -> DATA, counter and bit index cleared.
  - Sample 1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - Samples at t0+HALF+k*CLKS_PER_BIT for k=1..DATA_BITS.
  - Each sample shifts in at the MSB and shifts right, so the first bit lands in bit 0.
  - After bit DATA_BITS-1 -> STOP.
- STOP:
  - Samples at t0+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
  - Sample 1 -> data_out <= shift register, valid_out=1 in the next cycle, -> IDLE.
  - Sample 0 -> frame_err_out=1 in the next cycle, data_out unchanged, -> BREAK.
- BREAK: stays until rxd_sync==1, then -> IDLE. This prevents a held-low line from being re-read as start bits.
- Latency: valid_out rises at cycle t0+HALF+(DATA_BITS+1)*CLKS_PER_BIT+1, i.e. t_fall+2 plus that offset relative to the rxd_in falling edge.
- Back-to-back frames: returning to IDLE mid-stop-bit allows a start edge immediately after the stop bit, so no idle gap is needed.
- valid_out and frame_err_out:
  - Both are registered and never asserted together.
  - Each is high for exactly one cycle per frame.
- Counters wrap only under FSM control. The clock counter is clog2(CLKS_PER_BIT) bits wide; the bit index is clog2(DATA_BITS+1) bits wide.

Decomposition:
- Package rs232_pkg holds:
  - FSM state encoding constants (IDLE, START, DATA, STOP, BREAK).
  - DEFAULT_CLKS_PER_BIT = 434 and DEFAULT_DATA_BITS = 8, shared with the transmitter.
- One sub-module: rs232_sync, a 2-flop synchroniser.
  - Ports: clk_in, rst_in, d_in, q_out. Reset value 1.
  - Reused for any other asynchronous input.

Test Plan (bench runs with CLKS_PER_BIT=16, DATA_BITS=8):
- Reset: rst_in=1 for 3 cycles with rxd_in=1, then release and idle 50 cycles -> data_out=0x00, valid_out, frame_err_out and busy_out stay 0 throughout.
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> valid_out high for exactly one cycle at t_fall+2+8+144+1, data_out=0xA5, frame_err_out=0.
- Back-to-back 0x00 then 0xFF with no idle between frames -> two valid pulses 160 cycles apart, carrying 0x00 then 0xFF. No frame_err_out.
- Glitch: rxd_in low for 3 cycles, then high -> busy_out returns to 0 within HALF+3 cycles of the edge, with no valid_out and no frame_err_out.
- Framing error: 0x3C sent with stop=0, then line held low 40 bit periods, then high, then frame 0x5A -> one frame_err_out pulse, data_out keeps its prior value during BREAK, then valid_out with data_out=0x5A.
- Reset mid-frame: rst_in pulsed after 4 data bits of 0x77 -> IDLE, busy_out=0, no strobe for 0x77. The next full frame 0x81 yields valid_out with data_out=0x81.
